mem_register: RTL and testbench

MEM_REGISTER -- requirements
Module: mem_register

---
 rtl/mem_register.sv | 135 +++++++++++++
 tb/tb_mem_register.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_register.sv
// MEM-stage pipeline register: one-cycle copy of execute results and control with stall/hold.
// Optional bubble insertion through a flush port when MEMREG_FLUSH_EN is defined.
module mem_register (
  input  logic        clock,
  input  logic        resetn,
  input  logic        stall,
`ifdef MEMREG_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        dMEMWR,
  input  logic        dBRANCH,
  input  logic        dMEMTOREG,
  input  logic        dREGWR,
  input  logic [1:0]  dDSIZE,
  input  logic [1:0]  dFPOINT,
  input  logic        dZERO,
  input  logic        dLOADEXT,
  input  logic        dJUMP,
  input  logic        dJAL,
  input  logic        dJAR,
  input  logic [4:0]  dRW,
  input  logic [31:0] dEXECRESULT,
  input  logic [31:0] dBRANCHTARGET,
  input  logic [31:0] dBUSB,
  output logic        qMEMWR,
  output logic        qBRANCH,
  output logic        qMEMTOREG,
  output logic        qREGWR,
  output logic [1:0]  qDSIZE,
  output logic [1:0]  qFPOINT,
  output logic        qZERO,
  output logic        qLOADEXT,
  output logic        qJUMP,
  output logic        qJAL,
  output logic        qJAR,
  output logic [4:0]  qRW,
  output logic [31:0] qEXECRESULT,
  output logic [31:0] qBRANCHTARGET,
  output logic [31:0] qBUSB
);

  localparam int unsigned SizeW = 2;
  localparam int unsigned FpW   = 2;
  localparam int unsigned RegW  = 5;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic             memwr;
    logic             branch;
    logic             memtoreg;
    logic             regwr;
    logic [SizeW-1:0] dsize;
    logic [FpW-1:0]   fpoint;
    logic             zero;
    logic             loadext;
    logic             jump;
    logic             jal;
    logic             jar;
    logic [RegW-1:0]  rw;
    logic [DataW-1:0] execresult;
    logic [DataW-1:0] branchtarget;
    logic [DataW-1:0] busb;
  } memreg_t;

  memreg_t stage_in_c;
  memreg_t stage_d;
  memreg_t stage_q;
  logic    flush_c;

`ifdef MEMREG_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign stage_in_c = '{
    memwr:        dMEMWR,
    branch:       dBRANCH,
    memtoreg:     dMEMTOREG,
    regwr:        dREGWR,
    dsize:        dDSIZE,
    fpoint:       dFPOINT,
    zero:         dZERO,
    loadext:      dLOADEXT,
    jump:         dJUMP,
    jal:          dJAL,
    jar:          dJAR,
    rw:           dRW,
    execresult:   dEXECRESULT,
    branchtarget: dBRANCHTARGET,
    busb:         dBUSB
  };

  // Flush beats stall: data loads, but every state-changing control bit is squashed.
  always_comb begin
    stage_d = stage_q;
    if (flush_c) begin
      stage_d          = stage_in_c;
      stage_d.memwr    = 1'b0;
      stage_d.branch   = 1'b0;
      stage_d.memtoreg = 1'b0;
      stage_d.regwr    = 1'b0;
      stage_d.jump     = 1'b0;
      stage_d.jal      = 1'b0;
      stage_d.jar      = 1'b0;
    end else if (!stall) begin
      stage_d = stage_in_c;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign qMEMWR        = stage_q.memwr;
  assign qBRANCH       = stage_q.branch;
  assign qMEMTOREG     = stage_q.memtoreg;
  assign qREGWR        = stage_q.regwr;
  assign qDSIZE        = stage_q.dsize;
  assign qFPOINT       = stage_q.fpoint;
  assign qZERO         = stage_q.zero;
  assign qLOADEXT      = stage_q.loadext;
  assign qJUMP         = stage_q.jump;
  assign qJAL          = stage_q.jal;
  assign qJAR          = stage_q.jar;
  assign qRW           = stage_q.rw;
  assign qEXECRESULT   = stage_q.execresult;
  assign qBRANCHTARGET = stage_q.branchtarget;
  assign qBUSB         = stage_q.busb;

endmodule

// File: tb/tb_mem_register.sv
// Directed bench for mem_register; flush vectors are built only when MEMREG_FLUSH_EN is defined.
module tb_mem_register;

  logic        clock;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic        dMEMWR, dBRANCH, dMEMTOREG, dREGWR;
  logic [1:0]  dDSIZE, dFPOINT;
  logic        dZERO, dLOADEXT, dJUMP, dJAL, dJAR;
  logic [4:0]  dRW;
  logic [31:0] dEXECRESULT, dBRANCHTARGET, dBUSB;
  logic        qMEMWR, qBRANCH, qMEMTOREG, qREGWR;
  logic [1:0]  qDSIZE, qFPOINT;
  logic        qZERO, qLOADEXT, qJUMP, qJAL, qJAR;
  logic [4:0]  qRW;
  logic [31:0] qEXECRESULT, qBRANCHTARGET, qBUSB;
  logic [113:0] qall;

  int n_checks = 0;
  int n_pass   = 0;

  assign qall = {qMEMWR, qBRANCH, qMEMTOREG, qREGWR, qDSIZE, qFPOINT, qZERO, qLOADEXT,
                 qJUMP, qJAL, qJAR, qRW, qEXECRESULT, qBRANCHTARGET, qBUSB};

  mem_register dut (
    .clock(clock), .resetn(resetn), .stall(stall),
`ifdef MEMREG_FLUSH_EN
    .flush(flush),
`endif
    .dMEMWR(dMEMWR), .dBRANCH(dBRANCH), .dMEMTOREG(dMEMTOREG), .dREGWR(dREGWR),
    .dDSIZE(dDSIZE), .dFPOINT(dFPOINT), .dZERO(dZERO), .dLOADEXT(dLOADEXT),
    .dJUMP(dJUMP), .dJAL(dJAL), .dJAR(dJAR), .dRW(dRW),
    .dEXECRESULT(dEXECRESULT), .dBRANCHTARGET(dBRANCHTARGET), .dBUSB(dBUSB),
    .qMEMWR(qMEMWR), .qBRANCH(qBRANCH), .qMEMTOREG(qMEMTOREG), .qREGWR(qREGWR),
    .qDSIZE(qDSIZE), .qFPOINT(qFPOINT), .qZERO(qZERO), .qLOADEXT(qLOADEXT),
    .qJUMP(qJUMP), .qJAL(qJAL), .qJAR(qJAR), .qRW(qRW),
    .qEXECRESULT(qEXECRESULT), .qBRANCHTARGET(qBRANCHTARGET), .qBUSB(qBUSB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_d(input logic [113:0] v);
    {dMEMWR, dBRANCH, dMEMTOREG, dREGWR, dDSIZE, dFPOINT, dZERO, dLOADEXT,
     dJUMP, dJAL, dJAR, dRW, dEXECRESULT, dBRANCHTARGET, dBUSB} = v;
  endtask

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    set_d({114{1'b1}});
    #3;
    check("reset_no_edge", 128'(qall), 128'd0);
    tick();
    check("reset_held_over_edge", 128'(qall), 128'd0);
    resetn = 1'b1;
    tick();
    check("first_edge_all_ones", 128'(qall), 128'({114{1'b1}}));

    // Load pattern 1
    set_d('0);
    dMEMTOREG = 1'b1; dZERO = 1'b1; dDSIZE = 2'b01; dEXECRESULT = 32'd8;
    tick();
    check("load1_memtoreg", 128'(qMEMTOREG), 128'd1);
    check("load1_zero", 128'(qZERO), 128'd1);
    check("load1_dsize", 128'(qDSIZE), 128'd1);
    check("load1_exec", 128'(qEXECRESULT), 128'd8);
    check("load1_memwr", 128'(qMEMWR), 128'd0);
    check("load1_branchtarget", 128'(qBRANCHTARGET), 128'd0);

    // Load pattern 2
    dMEMWR = 1'b1; dBRANCH = 1'b1; dREGWR = 1'b1; dDSIZE = 2'b00; dEXECRESULT = 32'd9;
    tick();
    check("load2_ctrl", 128'({qMEMWR, qBRANCH, qMEMTOREG, qREGWR}), 128'(4'b1111));
    check("load2_dsize", 128'(qDSIZE), 128'd0);
    check("load2_exec", 128'(qEXECRESULT), 128'd9);

    // Stall holds everything for three edges
    stall = 1'b1;
    dEXECRESULT = 32'hDEADBEEF;
    dMEMWR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_exec", 128'(qEXECRESULT), 128'd9);
      check("stall_memwr", 128'(qMEMWR), 128'd1);
    end
    stall = 1'b0;
    tick();
    check("unstall_exec", 128'(qEXECRESULT), 128'hDEADBEEF);
    check("unstall_memwr", 128'(qMEMWR), 128'd0);

    // Reserved access size passes unchanged
    dDSIZE = 2'b11;
    tick();
    check("dsize_reserved", 128'(qDSIZE), 128'd3);

`ifdef MEMREG_FLUSH_EN
    set_d({114{1'b1}});
    dRW = 5'd31; dBUSB = 32'h1234;
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_ctrl_cleared",
          128'({qMEMWR, qBRANCH, qMEMTOREG, qREGWR, qJUMP, qJAL, qJAR}), 128'd0);
    check("flush_rw", 128'(qRW), 128'd31);
    check("flush_busb", 128'(qBUSB), 128'h1234);
    check("flush_exec", 128'(qEXECRESULT), 128'hFFFFFFFF);
    check("flush_loadext", 128'(qLOADEXT), 128'd1);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("post_flush_ctrl",
          128'({qMEMWR, qBRANCH, qMEMTOREG, qREGWR, qJUMP, qJAL, qJAR}), 128'h7F);
`endif

    // Async reset pulse between edges
    set_d({114{1'b1}});
    tick();
    check("pre_reset_loaded", 128'(qall), 128'({114{1'b1}}));
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_immediate", 128'(qall), 128'd0);
    resetn = 1'b1;
    #1;
    check("async_reset_no_resurrect", 128'(qall), 128'd0);

    // Full-width fields
    set_d('0);
    dBRANCHTARGET = 32'hFFFFFFFC; dFPOINT = 2'b11; dRW = 5'd0;
    tick();
    check("full_branchtarget", 128'(qBRANCHTARGET), 128'hFFFFFFFC);
    check("full_fpoint", 128'(qFPOINT), 128'd3);
    check("full_rw", 128'(qRW), 128'd0);
    check("full_other", 128'({qEXECRESULT, qBUSB}), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
